bundle_stream_capture: RTL
==========================

Name: bundle_stream_capture

Overview:
- Downstream consumer of the 4-bit parity-feedback bundle (index, clock, inp, out).
- Samples the bundle each qualified cycle, checks that `out` is consistent with the XOR of `inp`, and measures the state-recurrence period of `inp`.
- Buffers samples in a small FIFO drained by a valid/ready sink, such as a logger or a bus bridge.

Parameters:
- WIDTH, 4: width of inp vector.
- IDX_W, 2: width of index field.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the period counter and the drop counter.

Ports:
- clock  input  1  rising-edge clock shared with the bundle.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  bundle sample qualifier.
- in_index  input  IDX_W  bundle index.
- in_inp  input  WIDTH  bundle state vector.
- in_out  input  1  bundle parity output.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  sink accepts head.
- out_data  output  IDX_W+WIDTH+1  head entry, packed as {index, inp, out}, with out as the LSB.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; set when a sample is dropped.
- parity_err  output  1  sticky; set when in_out differs from the XOR of in_inp on an accepted-or-dropped valid sample.
- period  output  CNT_W  measured recurrence period.
- period_valid  output  1  high in state DONE.

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: FIFO empty, out_valid=0, out_data=0, full=0, overflow=0, parity_err=0, period=0, period_valid=0, FSM in IDLE.
  - Reset mid-operation discards all FIFO contents and measurement state on the next edge.
- FIFO:
  - Push on a clock edge when in_valid is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Pop when out_valid and out_ready are both high.
  - Simultaneous push and pop leaves the count unchanged.
  - Registered output: a sample pushed into an empty FIFO appears on out_data with out_valid=1 one cycle after the push edge.
  - out_data holds steady while out_valid is high and out_ready is low.
  - Pointers wrap modulo DEPTH. full is asserted exactly when count equals DEPTH.
- Drop: when in_valid is high, the FIFO is full, and no pop occurs, the sample is discarded and overflow is set. overflow clears only on reset.
- Parity check: applies to every sample with in_valid high, whether pushed or dropped. A mismatch sets parity_err on the same edge; it clears only on reset.
- Period FSM (advances only on edges where in_valid is high):
  - IDLE: capture in_inp into ref, clear cnt, go to COUNT.
  - COUNT: cnt <= cnt+1.
    - If in_inp equals ref: period <= cnt+1, go to DONE.
    - Else if cnt+1 reaches all-ones: period <= 0, go to DONE (not found).
  - DONE: hold. period_valid=1. Only reset leaves DONE.
- Width rules:
  - cnt is CNT_W bits wide and saturates; it does not wrap.
  - The XOR reduction covers all WIDTH bits.

Optional Feature:
- Macro: BUNDLE_CAPTURE_DROPCNT_EN.
- When defined:
  - Adds output port drop_count of width CNT_W.
  - drop_count increments on each dropped sample, saturates at all-ones, and resets to 0.
- When not defined: the port and counter are absent. overflow alone reports drops.

Test Plan:
- Reset mid-stream: push 3 samples, assert reset for 1 cycle -> next cycle out_valid=0, full=0, overflow=0, period_valid=0.
- Period measurement: in_valid held high, out_ready=1, in_inp sequence 1111, 1110, 1110, 1110, 1111 with consistent in_out -> period=4 and period_valid=1 after the 5th edge.
- Latency and order: out_ready=0, push {idx=0, inp=1111, out=0} -> out_valid=1 and out_data=7'b0011110 one cycle later. Then raise out_ready -> entries drain in push order.
- Full and overflow: out_ready=0, 9 consecutive valid samples with DEPTH=8 -> full=1 after 8 samples, overflow=1 after the 9th, and the 9th sample never appears on out_data. With BUNDLE_CAPTURE_DROPCNT_EN defined, drop_count=1.
- Full with simultaneous pop: FIFO full, in_valid=1 and out_ready=1 -> new sample accepted, full stays 1, overflow stays 0.
- Parity error: in_inp=1111 with in_out=1 -> parity_err=1 after that edge and stays 1 through later good samples. Period saturation: ref never recurs for 255 valid samples -> period=0 and period_valid=1.

Source files
------------

// File: rtl/bundle_stream_capture.sv
// Bundle sampler: parity check, inp recurrence period, valid/ready FIFO.
// Optional drop counter output enabled by BUNDLE_CAPTURE_DROPCNT_EN.
module bundle_stream_capture #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [IDX_W-1:0]       in_index,
  input  logic [WIDTH-1:0]       in_inp,
  input  logic                   in_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W+WIDTH:0]   out_data,
  output logic                   full,
  output logic                   overflow,
  output logic                   parity_err,
  output logic [CNT_W-1:0]       period,
`ifdef BUNDLE_CAPTURE_DROPCNT_EN
  output logic [CNT_W-1:0]       drop_count,
`endif
  output logic                   period_valid
);

  localparam int DW = IDX_W + WIDTH + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_overflow;
  logic             r_parity_err;
  state_t           r_state;
  logic [WIDTH-1:0] r_ref;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_perr;
  logic [DW-1:0]    w_in_data;
  logic [AW-1:0]    w_rptr_n;
  logic [AW:0]      w_count_n;
  logic [DW-1:0]    w_head_n;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_full    = (r_count == L_DEPTH);
  assign w_pop     = r_out_valid & out_ready;
  assign w_push    = in_valid & (~w_full | w_pop);
  assign w_drop    = in_valid & w_full & ~w_pop;
  assign w_perr    = in_valid & (in_out != ^in_inp);
  assign w_in_data = {in_index, in_inp, in_out};
  assign w_rptr_n  = w_pop ? r_rptr + AW'(1) : r_rptr;

  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop)
      w_count_n = r_count + (AW+1)'(1);
    else if (w_pop && !w_push)
      w_count_n = r_count - (AW+1)'(1);
  end

  // New head bypasses memory when it is the entry written this edge.
  assign w_head_n = (w_push && (w_rptr_n == r_wptr)) ?
                    w_in_data : r_mem[w_rptr_n];

  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wptr] <= w_in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      r_rptr      <= w_rptr_n;
      r_count     <= w_count_n;
      r_out_valid <= (w_count_n != '0);
      if (w_count_n != '0)
        r_out_data <= w_head_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_perr)
        r_parity_err <= 1'b1;
    end
  end

`ifdef BUNDLE_CAPTURE_DROPCNT_EN
  logic [CNT_W-1:0] r_drop_count;

  always_ff @(posedge clock) begin
    if (reset)
      r_drop_count <= '0;
    else if (w_drop && r_drop_count != '1)
      r_drop_count <= r_drop_count + CNT_W'(1);
  end

  assign drop_count = r_drop_count;
`endif

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ref          <= '0;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          r_ref   <= in_inp;
          r_cnt   <= '0;
          r_state <= S_COUNT;
        end
        S_COUNT: begin
          r_cnt <= w_cnt_inc;
          if (in_inp == r_ref) begin
            r_period       <= w_cnt_inc;
            r_period_valid <= 1'b1;
            r_state        <= S_DONE;
          end else if (w_cnt_inc == '1) begin
            r_period       <= '0;
            r_period_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign full         = w_full;
  assign overflow     = r_overflow;
  assign parity_err   = r_parity_err;
  assign period       = r_period;
  assign period_valid = r_period_valid;

endmodule
